// File: rtl/pic_ctrl_sync.sv
// PIC control block: ICW/OCW programming, IRR/IMR/ISR registers and the INTA
// acknowledge sequencer with 2-pulse/3-pulse modes and split cascade lines.
module pic_ctrl_sync #(
    parameter int N_IR = 8,
    parameter bit SYNC_INTA = 1'b1,
    localparam int ID_W = $clog2(N_IR)
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            SP,
    input  logic            INTA,
    input  logic [7:0]      DATA_IN,
    input  logic [3:0]      ICWs_Flags,
    input  logic [2:0]      OCWs_Flags,
    input  logic [N_IR-1:0] IR,
    input  logic [ID_W-1:0] INT_VEC,
    input  logic [2:0]      CAS_IN,
    output logic [2:0]      CAS_OUT,
    output logic            CAS_OE,
    output logic [N_IR-1:0] IM,
    output logic [N_IR-1:0] IRR_masked,
    output logic [N_IR-1:0] ISR,
    output logic            INT,
    output logic            LTIM,
    output logic            AEOI,
    output logic            UPM,
    output logic [1:0]      Read_command,
    output logic [7:0]      opperation_OCW2,
    output logic            OCW2_VALID,
    output logic            INIT_DONE,
    output logic [7:0]      IV,
    output logic            IV_READY,
    output logic            first_ACK,
    output logic            second_ACK
);

    typedef enum logic [2:0] {IDLE, W_ICW2, W_ICW3, W_ICW4, READY} init_state_t;
    typedef enum logic [1:0] {A_IDLE, P1, P2, P3} ack_state_t;

    init_state_t init_q, init_d;
    ack_state_t  ack_q, ack_d;

    logic            sngl, ic4;
    logic [7:0]      icw2, icw3;
    logic [N_IR-1:0] im_q, isr_q, isr_d, irr_q, irr_d, ir_q;
    logic            int_q, ocw2_valid_q;
    logic [1:0]      rd_cmd_q;
    logic [7:0]      ocw2_q;
    logic [ID_W-1:0] vec;
    logic            ack_en, cas_master;

    logic inta_s, inta_d;
    logic fall, rise, pulse_low;
    logic icw1_stb, ready;
    logic ocw1_stb, ocw2_stb, ocw3_stb;
    logic p1_fall, ack_done, slave_ok, eoi_found;

    if (SYNC_INTA) begin : g_sync
        logic s1, s2;
        always_ff @(posedge CLK) begin
            if (RESET) begin
                s1 <= 1'b0;
                s2 <= 1'b0;
            end else begin
                s1 <= INTA;
                s2 <= s1;
            end
        end
        assign inta_s = s2;
    end else begin : g_nosync
        assign inta_s = INTA;
    end

    assign fall      = inta_d & ~inta_s;
    assign rise      = ~inta_d & inta_s;
    // Both stages low: excludes the edge-detect cycle so a byte never leaks
    // into the start of the following pulse.
    assign pulse_low = ~inta_d & ~inta_s;

    assign icw1_stb = ICWs_Flags[0];
    assign ready    = (init_q == READY);
    assign ocw1_stb = OCWs_Flags[0] & ready;
    assign ocw2_stb = OCWs_Flags[1] & ready;
    assign ocw3_stb = OCWs_Flags[2] & ready;

    assign p1_fall  = (ack_q == A_IDLE) & fall;
    assign ack_done = rise & (((ack_q == P2) & UPM) | (ack_q == P3));
    assign slave_ok = sngl | SP | (CAS_IN == icw3[2:0]);

    // Initialisation FSM
    always_ff @(posedge CLK) begin
        if (RESET) init_q <= IDLE;
        else       init_q <= init_d;
    end

    always_comb begin
        init_d = init_q;
        if (icw1_stb) begin
            init_d = W_ICW2;
        end else begin
            case (init_q)
                W_ICW2: if (ICWs_Flags[1]) init_d = !sngl ? W_ICW3 : (ic4 ? W_ICW4 : READY);
                W_ICW3: if (ICWs_Flags[2]) init_d = ic4 ? W_ICW4 : READY;
                W_ICW4: if (ICWs_Flags[3]) init_d = READY;
                default: init_d = init_q;
            endcase
        end
    end

    always_comb begin
        INIT_DONE = (init_q == READY);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            LTIM         <= 1'b0;
            sngl         <= 1'b0;
            ic4          <= 1'b0;
            AEOI         <= 1'b0;
            UPM          <= 1'b0;
            icw2         <= '0;
            icw3         <= '0;
            im_q         <= '0;
            rd_cmd_q     <= 2'b10;
            ocw2_q       <= '0;
            ocw2_valid_q <= 1'b0;
        end else if (icw1_stb) begin
            LTIM         <= DATA_IN[3];
            sngl         <= DATA_IN[1];
            ic4          <= DATA_IN[0];
            AEOI         <= 1'b0;
            UPM          <= 1'b0;
            im_q         <= '0;
            ocw2_valid_q <= 1'b0;
        end else begin
            if (init_q == W_ICW2 && ICWs_Flags[1]) icw2 <= DATA_IN;
            if (init_q == W_ICW3 && ICWs_Flags[2]) icw3 <= DATA_IN;
            if (init_q == W_ICW4 && ICWs_Flags[3]) begin
                AEOI <= DATA_IN[1];
                UPM  <= DATA_IN[0];
            end
            if (ocw1_stb) im_q <= DATA_IN[N_IR-1:0];
            if (ocw3_stb && DATA_IN[1]) rd_cmd_q <= DATA_IN[1:0];
            if (ocw2_stb) ocw2_q <= DATA_IN;
            ocw2_valid_q <= ocw2_stb;
        end
    end

    // Acknowledge FSM
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ack_q  <= A_IDLE;
            inta_d <= 1'b0;
        end else begin
            ack_q  <= ack_d;
            inta_d <= inta_s;
        end
    end

    always_comb begin
        ack_d = ack_q;
        if (icw1_stb) begin
            ack_d = A_IDLE;
        end else begin
            case (ack_q)
                A_IDLE: if (fall) ack_d = P1;
                P1:     if (fall) ack_d = P2;
                P2: begin
                    if (fall && !UPM)     ack_d = P3;
                    else if (rise && UPM) ack_d = A_IDLE;
                end
                P3:     if (rise) ack_d = A_IDLE;
                default: ack_d = A_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET || icw1_stb) begin
            vec        <= '0;
            ack_en     <= 1'b0;
            cas_master <= 1'b0;
        end else if (p1_fall) begin
            vec        <= INT_VEC;
            ack_en     <= slave_ok;
            cas_master <= ~sngl & SP & icw3[INT_VEC];
        end
    end

    always_comb begin
        first_ACK  = (ack_q == P1);
        second_ACK = (ack_q == P2);
        CAS_OE     = cas_master & (ack_q != A_IDLE);
        CAS_OUT    = '0;
        if (CAS_OE) CAS_OUT[ID_W-1:0] = vec;
        IV         = '0;
        IV_READY   = 1'b0;
        case (ack_q)
            P1: if (!UPM) begin
                IV       = 8'hCD;
                IV_READY = pulse_low & ack_en;
            end
            P2: begin
                IV       = {icw2[7:ID_W], vec};
                IV_READY = pulse_low & ack_en & ~cas_master;
            end
            P3: begin
                IV       = icw2;
                IV_READY = pulse_low & ack_en & ~cas_master;
            end
            default: IV_READY = 1'b0;
        endcase
    end

    // ISR/IRR update: ack set, then EOI and AEOI clears applied together
    always_comb begin
        isr_d     = isr_q;
        eoi_found = 1'b0;
        if (p1_fall && slave_ok) isr_d[INT_VEC] = 1'b1;
        if (ocw2_stb && DATA_IN[7:5] == 3'b001) begin
            for (int unsigned i = 0; i < N_IR; i++) begin
                if (!eoi_found && isr_q[i]) begin
                    isr_d[i]  = 1'b0;
                    eoi_found = 1'b1;
                end
            end
        end
        if (ocw2_stb && DATA_IN[7:5] == 3'b011) isr_d[DATA_IN[ID_W-1:0]] = 1'b0;
        if (ack_done && AEOI && ack_en) isr_d[vec] = 1'b0;

        irr_d = LTIM ? IR : (irr_q | (IR & ~ir_q));
        if (!LTIM && p1_fall && slave_ok) irr_d[INT_VEC] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            isr_q <= '0;
            irr_q <= '0;
            ir_q  <= '0;
            int_q <= 1'b0;
        end else begin
            ir_q  <= IR;
            int_q <= ready & |(irr_q & ~im_q);
            if (icw1_stb) begin
                isr_q <= '0;
                irr_q <= '0;
            end else begin
                isr_q <= isr_d;
                irr_q <= irr_d;
            end
        end
    end

    always_comb begin
        IM              = im_q;
        ISR             = isr_q;
        IRR_masked      = irr_q & ~im_q;
        INT             = int_q;
        Read_command    = rd_cmd_q;
        opperation_OCW2 = ocw2_q;
        OCW2_VALID      = ocw2_valid_q;
    end

endmodule

// File: tb/tb_pic_ctrl_sync.sv
// Scenario-driven bench for pic_ctrl_sync; acknowledge bytes are checked
// against a queue of expected IV values filled as each sequence is started.
module tb_pic_ctrl_sync;

    logic       clk = 1'b0;
    logic       rst, sp, inta;
    logic [7:0] data_in;
    logic [3:0] icw_f;
    logic [2:0] ocw_f;
    logic [7:0] ir;
    logic [2:0] int_vec, cas_in;

    logic [2:0] CAS_OUT;
    logic       CAS_OE, INT, LTIM, AEOI, UPM, OCW2_VALID, INIT_DONE;
    logic       IV_READY, first_ACK, second_ACK;
    logic [7:0] IM, IRR_masked, ISR, opperation_OCW2, IV;
    logic [1:0] Read_command;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;
    logic       prev_rdy = 1'b0;

    always #5 clk = ~clk;

    pic_ctrl_sync #(.N_IR(8), .SYNC_INTA(1'b1)) dut (
        .CLK(clk), .RESET(rst), .SP(sp), .INTA(inta), .DATA_IN(data_in),
        .ICWs_Flags(icw_f), .OCWs_Flags(ocw_f), .IR(ir), .INT_VEC(int_vec),
        .CAS_IN(cas_in), .CAS_OUT(CAS_OUT), .CAS_OE(CAS_OE), .IM(IM),
        .IRR_masked(IRR_masked), .ISR(ISR), .INT(INT), .LTIM(LTIM),
        .AEOI(AEOI), .UPM(UPM), .Read_command(Read_command),
        .opperation_OCW2(opperation_OCW2), .OCW2_VALID(OCW2_VALID),
        .INIT_DONE(INIT_DONE), .IV(IV), .IV_READY(IV_READY),
        .first_ACK(first_ACK), .second_ACK(second_ACK)
    );

    // Each new IV_READY assertion consumes one expected byte
    always @(negedge clk) begin
        if (IV_READY && !prev_rdy) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL iv_unexpected got=%h want=no_byte", IV);
            end else begin
                exp_b = exp_q.pop_front();
                if (IV !== exp_b) begin
                    bad++;
                    $display("FAIL iv_byte got=%h want=%h", IV, exp_b);
                end
            end
        end
        prev_rdy = IV_READY;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr_icw(input int k, input logic [7:0] d);
        data_in = d;
        icw_f = '0;
        icw_f[k] = 1'b1;
        cyc(1);
        icw_f = '0;
    endtask

    task automatic wr_ocw(input int k, input logic [7:0] d);
        data_in = d;
        ocw_f = '0;
        ocw_f[k] = 1'b1;
        cyc(1);
        ocw_f = '0;
    endtask

    task automatic init_pic(input logic [7:0] i1, input logic [7:0] i2,
                            input logic [7:0] i3, input logic [7:0] i4);
        wr_icw(0, i1);
        wr_icw(1, i2);
        if (!i1[1]) wr_icw(2, i3);
        if (i1[0]) wr_icw(3, i4);
    endtask

    task automatic inta_low();
        inta = 1'b0;
        cyc(4);
    endtask

    task automatic inta_high();
        inta = 1'b1;
        cyc(4);
    endtask

    task automatic check_queue_empty(input string name);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_iv_missing left=%0d want=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(3);
        total++;
        if ({INIT_DONE, INT, CAS_OE, IV_READY, first_ACK, second_ACK, OCW2_VALID, LTIM, AEOI, UPM} !== 10'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b want=0", {INIT_DONE, INT, CAS_OE, IV_READY, first_ACK, second_ACK, OCW2_VALID, LTIM, AEOI, UPM});
        end
        total++;
        if ({IM, ISR, IRR_masked, opperation_OCW2, IV, CAS_OUT} !== 43'b0) begin
            bad++;
            $display("FAIL reset_regs got=%h want=0", {IM, ISR, IRR_masked, opperation_OCW2, IV, CAS_OUT});
        end
        total++;
        if (Read_command !== 2'b10) begin
            bad++;
            $display("FAIL reset_read_command got=%b want=10", Read_command);
        end
        rst = 1'b0;
        cyc(1);
    endtask

    task automatic test_init();
        wr_icw(0, 8'h13);
        wr_icw(1, 8'h20);
        wr_icw(2, 8'hFF);
        total++;
        if (INIT_DONE !== 1'b0) begin
            bad++;
            $display("FAIL init_icw3_ignored got=%b want=0", INIT_DONE);
        end
        wr_icw(3, 8'h03);
        total++;
        if ({INIT_DONE, LTIM, AEOI, UPM} !== 4'b1011) begin
            bad++;
            $display("FAIL init_done got=%b want=1011", {INIT_DONE, LTIM, AEOI, UPM});
        end
        total++;
        if (Read_command !== 2'b10) begin
            bad++;
            $display("FAIL init_read_command got=%b want=10", Read_command);
        end
    endtask

    task automatic test_ack_x86();
        int_vec = 3'd3;
        ir = 8'h08;
        cyc(3);
        total++;
        if ({INT, IRR_masked} !== {1'b1, 8'h08}) begin
            bad++;
            $display("FAIL x86_request got=%h want=108", {INT, IRR_masked});
        end
        exp_q.push_back(8'h23);
        inta_low();
        total++;
        if ({first_ACK, second_ACK, ISR, IRR_masked} !== {2'b10, 8'h08, 8'h00}) begin
            bad++;
            $display("FAIL x86_p1 got=%h want=%h", {first_ACK, second_ACK, ISR, IRR_masked}, {2'b10, 8'h08, 8'h00});
        end
        inta_high();
        inta_low();
        total++;
        if ({first_ACK, second_ACK, ISR} !== {2'b01, 8'h08}) begin
            bad++;
            $display("FAIL x86_p2 got=%h want=%h", {first_ACK, second_ACK, ISR}, {2'b01, 8'h08});
        end
        inta_high();
        total++;
        if ({first_ACK, second_ACK, ISR, INT} !== 11'b0) begin
            bad++;
            $display("FAIL x86_aeoi_exit got=%h want=0", {first_ACK, second_ACK, ISR, INT});
        end
        check_queue_empty("x86");
    endtask

    task automatic test_ack_8080();
        ir = '0;
        init_pic(8'h13, 8'h40, 8'h00, 8'h00);
        int_vec = 3'd5;
        ir = 8'h20;
        cyc(3);
        exp_q.push_back(8'hCD);
        exp_q.push_back(8'h45);
        exp_q.push_back(8'h40);
        inta_low();
        inta_high();
        inta_low();
        inta_high();
        inta_low();
        total++;
        if ({first_ACK, second_ACK, ISR} !== {2'b00, 8'h20}) begin
            bad++;
            $display("FAIL i8080_p3 got=%h want=%h", {first_ACK, second_ACK, ISR}, {2'b00, 8'h20});
        end
        inta_high();
        total++;
        if (ISR !== 8'h20) begin
            bad++;
            $display("FAIL i8080_isr_held got=%h want=20", ISR);
        end
        check_queue_empty("i8080");
        wr_ocw(1, 8'h20);
        total++;
        if ({OCW2_VALID, opperation_OCW2, ISR} !== {1'b1, 8'h20, 8'h00}) begin
            bad++;
            $display("FAIL eoi_apply got=%h want=%h", {OCW2_VALID, opperation_OCW2, ISR}, {1'b1, 8'h20, 8'h00});
        end
        cyc(1);
        total++;
        if (OCW2_VALID !== 1'b0) begin
            bad++;
            $display("FAIL ocw2_valid_pulse got=%b want=0", OCW2_VALID);
        end
        wr_ocw(2, 8'h03);
        wr_ocw(2, 8'h01);
        total++;
        if (Read_command !== 2'b11) begin
            bad++;
            $display("FAIL ocw3_read_command got=%b want=11", Read_command);
        end
    endtask

    task automatic test_icw1_abort();
        int_vec = 3'd5;
        exp_q.push_back(8'hCD);
        exp_q.push_back(8'h45);
        inta_low();
        inta_high();
        inta_low();
        total++;
        if ({second_ACK, IV_READY} !== 2'b11) begin
            bad++;
            $display("FAIL abort_setup got=%b want=11", {second_ACK, IV_READY});
        end
        wr_icw(0, 8'h13);
        total++;
        if ({first_ACK, second_ACK, IV_READY, CAS_OE, INIT_DONE, ISR} !== 13'b0) begin
            bad++;
            $display("FAIL icw1_abort got=%h want=0", {first_ACK, second_ACK, IV_READY, CAS_OE, INIT_DONE, ISR});
        end
        inta_high();
        check_queue_empty("abort");
    endtask

    task automatic test_cascade_master();
        sp = 1'b1;
        ir = '0;
        init_pic(8'h11, 8'h20, 8'h04, 8'h01);
        int_vec = 3'd2;
        inta_low();
        total++;
        if ({first_ACK, CAS_OE, CAS_OUT} !== {2'b11, 3'd2}) begin
            bad++;
            $display("FAIL master_p1_cas got=%b want=11010", {first_ACK, CAS_OE, CAS_OUT});
        end
        inta_high();
        inta_low();
        total++;
        if ({second_ACK, CAS_OE, IV_READY, CAS_OUT} !== {3'b110, 3'd2}) begin
            bad++;
            $display("FAIL master_p2_cas got=%b want=110010", {second_ACK, CAS_OE, IV_READY, CAS_OUT});
        end
        inta_high();
        total++;
        if ({CAS_OE, ISR} !== {1'b0, 8'h04}) begin
            bad++;
            $display("FAIL master_exit got=%h want=004", {CAS_OE, ISR});
        end
        check_queue_empty("master");
    endtask

    task automatic test_reset_abort();
        int_vec = 3'd2;
        inta_low();
        inta_high();
        inta_low();
        total++;
        if ({second_ACK, CAS_OE} !== 2'b11) begin
            bad++;
            $display("FAIL reset_abort_setup got=%b want=11", {second_ACK, CAS_OE});
        end
        rst = 1'b1;
        cyc(1);
        total++;
        if ({first_ACK, second_ACK, CAS_OE, IV_READY, INIT_DONE, ISR, IM, Read_command} !== {5'b0, 16'h0, 2'b10}) begin
            bad++;
            $display("FAIL reset_abort got=%h want=%h", {first_ACK, second_ACK, CAS_OE, IV_READY, INIT_DONE, ISR, IM, Read_command}, {5'b0, 16'h0, 2'b10});
        end
        rst = 1'b0;
        inta_high();
        check_queue_empty("reset_abort");
    endtask

    task automatic test_cascade_slave();
        sp = 1'b0;
        init_pic(8'h11, 8'h30, 8'h02, 8'h01);
        int_vec = 3'd4;
        cas_in = 3'd1;
        inta_low();
        inta_high();
        inta_low();
        inta_high();
        total++;
        if (ISR !== 8'h00) begin
            bad++;
            $display("FAIL slave_mismatch_isr got=%h want=00", ISR);
        end
        check_queue_empty("slave_mismatch");
        cas_in = 3'd2;
        exp_q.push_back(8'h34);
        inta_low();
        inta_high();
        inta_low();
        inta_high();
        total++;
        if (ISR !== 8'h10) begin
            bad++;
            $display("FAIL slave_match_isr got=%h want=10", ISR);
        end
        check_queue_empty("slave_match");
    endtask

    task automatic test_mask();
        ir = '0;
        cyc(2);
        wr_ocw(0, 8'hFF);
        ir = 8'h0F;
        cyc(3);
        ir = '0;
        cyc(3);
        total++;
        if ({INT, IRR_masked} !== 9'b0) begin
            bad++;
            $display("FAIL mask_all got=%h want=0", {INT, IRR_masked});
        end
        wr_ocw(0, 8'h00);
        total++;
        if ({INT, IRR_masked} !== {1'b0, 8'h0F}) begin
            bad++;
            $display("FAIL unmask_now got=%h want=00f", {INT, IRR_masked});
        end
        cyc(1);
        total++;
        if (INT !== 1'b1) begin
            bad++;
            $display("FAIL unmask_int got=%b want=1", INT);
        end
    endtask

    initial begin
        rst = 1'b1;
        sp = 1'b1;
        inta = 1'b1;
        data_in = '0;
        icw_f = '0;
        ocw_f = '0;
        ir = '0;
        int_vec = '0;
        cas_in = '0;
        cyc(1);
        test_reset();
        test_init();
        test_ack_x86();
        test_ack_8080();
        test_icw1_abort();
        test_cascade_master();
        test_reset_abort();
        test_cascade_slave();
        test_mask();
        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
